// File: rtl/decode_queue_sequencer_pkg.sv
// Shared types and constants for the decode prefetch queue: sequencer states,
// fixed beat/window widths and the consume-length legality rule.
package decode_queue_sequencer_pkg;

  localparam int FETCH_BYTES  = 4;
  localparam int WINDOW_BYTES = 4;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    READY,
    FAULT
  } decode_queue_state_t;

  // A decoder may only report an instruction length of 1..4 bytes.
  function automatic logic length_legal(input logic [2:0] len);
    return (len != 3'd0) && (len <= 3'd4);
  endfunction

endpackage

// File: rtl/decode_byte_ring.sv
// Circular byte storage: one 4-byte write port at wr_ptr and a wrapped 4-byte
// read window at rd_ptr, with bytes beyond the current fill level forced to zero.
module decode_byte_ring
  import decode_queue_sequencer_pkg::*;
#(
  parameter int QUEUE_BYTES = 16,
  localparam int PW = $clog2(QUEUE_BYTES),
  localparam int CW = PW + 1
) (
  input  logic                          i_clk,
  input  logic                          i_wr_en,
  input  logic [PW-1:0]                 i_wr_ptr,
  input  logic [0:FETCH_BYTES-1][7:0]   i_wr_bytes,
  input  logic [PW-1:0]                 i_rd_ptr,
  input  logic [CW-1:0]                 i_count,
  output logic [0:WINDOW_BYTES-1][7:0]  o_window
);

  logic [7:0] mem [QUEUE_BYTES];

  // Pointer arithmetic is PW bits wide, so addresses wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < FETCH_BYTES; i++) begin
        mem[i_wr_ptr + PW'(i)] <= i_wr_bytes[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WINDOW_BYTES; gi++) begin : g_rd
      logic [PW-1:0] rd_addr;
      assign rd_addr     = i_rd_ptr + PW'(gi);
      assign o_window[gi] = (i_count > CW'(gi)) ? mem[rd_addr] : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/decode_queue_sequencer.sv
// Prefetch byte queue and sequencer: accepts fetch beats, presents a 4-byte
// decode window, advances by the decoded length and fills an issue slot.
module decode_queue_sequencer
  import decode_queue_sequencer_pkg::*;
#(
  parameter int QUEUE_BYTES = 16,
  localparam int PW = $clog2(QUEUE_BYTES),
  localparam int CW = PW + 1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_flush,
  input  logic            i_fetch_valid,
  input  logic [0:3][7:0] i_fetch_bytes,
  output logic            o_fetch_ready,
  output logic [0:3][7:0] o_window,
  output logic            o_window_valid,
  input  logic            i_consume,
  input  logic [2:0]      i_consume_length,
  output logic            o_issue_valid,
  input  logic            i_issue_ready,
  output logic [0:3][7:0] o_issue_bytes,
  output logic [2:0]      o_issue_length,
  output logic [CW-1:0]   o_count,
  output logic            o_error
);

  decode_queue_state_t state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic            issue_valid_reg, issue_valid_next;
  logic [0:3][7:0] issue_bytes_reg, issue_bytes_next;
  logic [2:0]      issue_length_reg, issue_length_next;
  logic            error_reg, error_next;

  logic [0:3][7:0] window;
  logic            slot_free, consume_req, fetch_acc, consume_acc, length_fault;

  decode_byte_ring #(.QUEUE_BYTES(QUEUE_BYTES)) u_ring (
    .i_clk      (i_clk),
    .i_wr_en    (fetch_acc),
    .i_wr_ptr   (wr_ptr_reg),
    .i_wr_bytes (i_fetch_bytes),
    .i_rd_ptr   (rd_ptr_reg),
    .i_count    (count_reg),
    .o_window   (window)
  );

  // Space check uses the registered count only; a same-cycle consume frees nothing.
  assign o_fetch_ready  = i_reset_n && (count_reg <= CW'(QUEUE_BYTES - FETCH_BYTES))
                          && !i_flush && (state_reg != FAULT);
  assign slot_free      = !issue_valid_reg || i_issue_ready;
  assign o_window_valid = (count_reg >= CW'(WINDOW_BYTES)) && slot_free
                          && (state_reg == READY) && !i_flush;

  assign fetch_acc    = i_fetch_valid && o_fetch_ready;
  assign consume_req  = i_consume && o_window_valid;
  assign consume_acc  = consume_req && length_legal(i_consume_length);
  assign length_fault = consume_req && !length_legal(i_consume_length);

  always_comb begin
    state_next        = state_reg;
    count_next        = count_reg;
    rd_ptr_next       = rd_ptr_reg;
    wr_ptr_next       = wr_ptr_reg;
    issue_valid_next  = issue_valid_reg;
    issue_bytes_next  = issue_bytes_reg;
    issue_length_next = issue_length_reg;
    error_next        = error_reg;

    if (i_flush) begin
      state_next        = EMPTY;
      count_next        = '0;
      rd_ptr_next       = '0;
      wr_ptr_next       = '0;
      issue_valid_next  = 1'b0;
      issue_bytes_next  = '0;
      issue_length_next = '0;
      error_next        = 1'b0;
    end else begin
      count_next = count_reg
                   + (fetch_acc   ? CW'(FETCH_BYTES)      : CW'(0))
                   - (consume_acc ? CW'(i_consume_length) : CW'(0));
      if (fetch_acc) begin
        wr_ptr_next = wr_ptr_reg + PW'(FETCH_BYTES);
      end

      if (consume_acc) begin
        rd_ptr_next       = rd_ptr_reg + PW'(i_consume_length);
        issue_valid_next  = 1'b1;
        issue_length_next = i_consume_length;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
          issue_bytes_next[i] = (3'(i) < i_consume_length) ? window[i] : 8'h00;
        end
      end else if (i_issue_ready && issue_valid_reg) begin
        issue_valid_next = 1'b0;
      end

      // FAULT is sticky until flush or reset; otherwise state follows the fill level.
      if (length_fault || state_reg == FAULT) begin
        state_next = FAULT;
        error_next = 1'b1;
      end else if (count_next == '0) begin
        state_next = EMPTY;
      end else if (count_next < CW'(WINDOW_BYTES)) begin
        state_next = FILL;
      end else begin
        state_next = READY;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg        <= EMPTY;
      count_reg        <= '0;
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      issue_valid_reg  <= 1'b0;
      issue_bytes_reg  <= '0;
      issue_length_reg <= '0;
      error_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      count_reg        <= count_next;
      rd_ptr_reg       <= rd_ptr_next;
      wr_ptr_reg       <= wr_ptr_next;
      issue_valid_reg  <= issue_valid_next;
      issue_bytes_reg  <= issue_bytes_next;
      issue_length_reg <= issue_length_next;
      error_reg        <= error_next;
    end
  end

  assign o_window       = window;
  assign o_issue_valid  = issue_valid_reg;
  assign o_issue_bytes  = issue_bytes_reg;
  assign o_issue_length = issue_length_reg;
  assign o_count        = count_reg;
  assign o_error        = error_reg;

endmodule
